// File: rtl/gf_div_if.sv
// Handshake and operand/result bundle for the sequential GF(2^8) divider.
// The master side issues start with operands; the slave side returns the quotient.
interface gf_div_if;
    logic       start;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic [7:0] out;
    logic       done;
    logic       busy;
    logic       div_zero;

    modport master (output start, in_1, in_2, input out, done, busy, div_zero);
    modport slave  (input start, in_1, in_2, output out, done, busy, div_zero);
endinterface

// File: rtl/gf_div.sv
// Sequential GF(2^8)/0x11D divider: out = in_1 * in_2^254 using one shared multiplier.
// Optional macro GF_DIV_ZERO_CHECK_EN short-circuits a zero divisor with div_zero=1.
module gf_div (
    input logic     clk,
    input logic     rst_n,
    gf_div_if.slave bus
);

`ifdef GF_DIV_ZERO_CHECK_EN
    typedef enum logic [2:0] {IDLE, SQR, MULA, FINSQ, MULD, ZERO} state_e;
`else
    typedef enum logic [2:0] {IDLE, SQR, MULA, FINSQ, MULD} state_e;
`endif

    // Shift-and-add multiply with the 0x11D reduction folded into each shift.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] d_q, d_d;
    logic [7:0] r_q, r_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] out_q, out_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic [7:0] op_x, op_y, prod;

    // Operand mux depends only on registered state, keeping the multiplier loop-free.
    always_comb begin
        op_x = r_q;
        op_y = r_q;
        case (state_q)
            MULA:    op_y = a_q;
            MULD:    op_x = d_q;
            default: ;
        endcase
    end

    assign prod = gf_mul(op_x, op_y);

`ifdef GF_DIV_ZERO_CHECK_EN
    logic div_zero_q, div_zero_d;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef GF_DIV_ZERO_CHECK_EN
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d    = bus.in_2;
                    d_d    = bus.in_1;
                    r_d    = bus.in_2;
                    cnt_d  = 3'd0;
                    busy_d = 1'b1;
`ifdef GF_DIV_ZERO_CHECK_EN
                    state_d = (bus.in_2 == 8'h00) ? ZERO : SQR;
`else
                    state_d = SQR;
`endif
                end
            end
            SQR: begin
                r_d     = prod;
                state_d = MULA;
            end
            MULA: begin
                r_d     = prod;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd5) ? FINSQ : SQR;
            end
            FINSQ: begin
                r_d     = prod;
                state_d = MULD;
            end
            MULD: begin
                out_d   = prod;
                done_d  = 1'b1;
                busy_d  = 1'b0;
`ifdef GF_DIV_ZERO_CHECK_EN
                div_zero_d = 1'b0;
`endif
                state_d = IDLE;
            end
`ifdef GF_DIV_ZERO_CHECK_EN
            ZERO: begin
                out_d      = 8'h00;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                div_zero_d = 1'b1;
                state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            d_q     <= 8'h00;
            r_q     <= 8'h00;
            cnt_q   <= 3'd0;
            out_q   <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef GF_DIV_ZERO_CHECK_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef GF_DIV_ZERO_CHECK_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
`ifdef GF_DIV_ZERO_CHECK_EN
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule
